axi4_burst_master: RTL and testbench

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

---
 rtl/axi4_burst_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// -----------------------------------------------------------------------------
// axi4_burst_master
//
// Single-outstanding AXI4 burst master. It accepts one command at a time,
// checks it for alignment and 4 KB crossing, then either writes an
// incrementing data pattern (cmd_seed + beat) or reads a burst back and
// compares every beat against the same pattern.
//
// Ports
//   ACLK, ARESET          clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write             1 = write burst, 0 = read burst
//   cmd_addr              start byte address, must be word aligned
//   cmd_len               AXI LEN (beats minus one)
//   cmd_seed              data pattern base; beat i carries cmd_seed + i
//   done/status           one-cycle completion pulse with its status
//                         (00 okay, 01 protocol, 10 slave error, 11 illegal)
//   mismatch_cnt          read-compare mismatches of the last command
//   AW*/W*/B*             AXI4 write address, data and response channels
//   AR*/R*                AXI4 read address and data channels
//
// The 4 KB check uses cmd_addr[11:2], so ADDR_WIDTH must be at least 12.
// All outputs come straight from flops; each flop is loaded from a _d value
// derived from the next state, so outputs line up with the state they
// belong to.
// -----------------------------------------------------------------------------
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  output logic                  done,
  output logic [1:0]            status,
  output logic [7:0]            mismatch_cnt,
  // write address channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // write response channel
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // read address channel
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // read data channel
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  localparam logic [1:0] ST_OKAY    = 2'b00;
  localparam logic [1:0] ST_PROTO   = 2'b01;
  localparam logic [1:0] ST_SLVERR  = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  // 4-byte beats, INCR bursts only
  localparam logic [2:0] BEAT_SIZE = 3'b010;

  // FSM and latched command
  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [7:0]              beat_q, beat_d;
  logic                    slverr_q, slverr_d;

  // registered outputs
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    done_q, done_d;
  logic [1:0]              status_q, status_d;
  logic [7:0]              mism_q, mism_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    wlast_q, wlast_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;

  // helpers
  logic [DATA_WIDTH-1:0]   exp_data;   // pattern expected on the current read beat
  logic [10:0]             span;       // last word index inside the 4 KB page
  logic                    illegal;
  logic                    beat_last;
  logic                    slv_now;

  assign exp_data  = seed_q + DATA_WIDTH'(beat_q);
  // Bit 10 set means the last word index passed 1023: the burst leaves the page.
  assign span      = {1'b0, addr_q[11:2]} + {3'b000, len_q};
  assign illegal   = (addr_q[1:0] != 2'b00) || span[10];
  assign beat_last = (beat_q == len_q);
  // Includes the beat being accepted now so an error on the final beat counts.
  assign slv_now   = slverr_q || (RRESP != 2'b00);

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    len_d    = len_q;
    seed_d   = seed_q;
    beat_d   = beat_q;
    slverr_d = slverr_q;
    mism_d   = mism_q;
    status_d = ST_OKAY;   // status is only meaningful alongside done

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d  = cmd_write;
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          seed_d   = cmd_seed;
          beat_d   = 8'd0;
          slverr_d = 1'b0;
          mism_d   = 8'd0;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if (illegal) begin
          status_d = ST_ILLEGAL;
          state_d  = DONE;
        end else if (write_q) begin
          state_d = WR_ADDR;
        end else begin
          state_d = RD_ADDR;
        end
      end

      // AWVALID is high for the whole state, so AWREADY alone is the handshake.
      WR_ADDR: begin
        if (AWREADY) state_d = WR_DATA;
      end

      WR_DATA: begin
        if (WREADY) begin
          if (beat_last) state_d = WR_RESP;
          else           beat_d  = beat_q + 8'd1;
        end
      end

      WR_RESP: begin
        if (BVALID) begin
          status_d = (BRESP == 2'b00) ? ST_OKAY : ST_SLVERR;
          state_d  = DONE;
        end
      end

      RD_ADDR: begin
        if (ARREADY) state_d = RD_DATA;
      end

      RD_DATA: begin
        if (RVALID) begin
          if ((RDATA != exp_data) && (mism_q != 8'hFF)) mism_d = mism_q + 8'd1;
          slverr_d = slv_now;
          // RLAST in the wrong place on either side is a protocol error,
          // which outranks any slave error seen so far.
          if (RLAST != beat_last) begin
            status_d = ST_PROTO;
            state_d  = DONE;
          end else if (beat_last) begin
            status_d = slv_now ? ST_SLVERR : ST_OKAY;
            state_d  = DONE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered, so they are valid from the
    // first cycle of that state and need no decode after the flops.
    cmd_ready_d = (state_d == IDLE);
    done_d      = (state_d == DONE);
    awvalid_d   = (state_d == WR_ADDR);
    wvalid_d    = (state_d == WR_DATA);
    wdata_d     = seed_d + DATA_WIDTH'(beat_d);
    wlast_d     = (state_d == WR_DATA) && (beat_d == len_d);
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_ADDR);
    rready_d    = (state_d == RD_DATA);
  end

  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments so every flop samples the old values.
    if (ARESET) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      seed_q      <= '0;
      beat_q      <= 8'd0;
      slverr_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_OKAY;
      mism_q      <= 8'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      beat_q      <= beat_d;
      slverr_q    <= slverr_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      status_q    <= status_d;
      mism_q      <= mism_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      wdata_q     <= wdata_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign done         = done_q;
  assign status       = status_q;
  assign mismatch_cnt = mism_q;

  // Address and length come from the latched command, so they stay stable
  // for as long as the matching VALID is waiting for READY.
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = BEAT_SIZE;
  assign AWVALID = awvalid_q;

  assign WDATA   = wdata_q;
  assign WLAST   = wlast_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = BEAT_SIZE;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_burst_master
//
// Self-checking bench for axi4_burst_master. A cycle-level slave inside the
// bench answers the AXI channels according to a per-command scenario record;
// directed records carry hand-derived expectations, random records get their
// expectations from a small arithmetic model of the command rules.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_burst_master;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] cmd_seed;
  logic          done;
  logic [1:0]    status;
  logic [7:0]    mismatch_cnt;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic          AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic          WLAST, WVALID, WREADY;
  logic [1:0]    BRESP, RRESP;
  logic          BVALID, BREADY;
  logic          RLAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .done(done), .status(status), .mismatch_cnt(mismatch_cnt),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // One command plus the slave behaviour to use and the expected outcome.
  // rlast_beat: -1 = RLAST on beat len, -2 = never, else beat index.
  // corrupt_beat / rresp_beat: -1 = none.
  typedef struct {
    bit         wr;
    logic [15:0] addr;
    logic [7:0] len;
    logic [31:0] seed;
    int         aw_delay;
    bit         w_toggle;
    logic [1:0] bresp;
    int         corrupt_beat;
    bit         corrupt_all;
    int         rlast_beat;
    int         rresp_beat;
    logic [1:0] exp_status;
    logic [7:0] exp_mism;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cur_id   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL [cmd %0d] %s: got 0x%0h, expected 0x%0h", cur_id, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [15:0] addr, logic [7:0] len, logic [31:0] seed,
                              int awd, bit tog, logic [1:0] bresp, int cb, bit ca,
                              int rl, int rr, logic [1:0] es, logic [7:0] em);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.seed = seed;
    v.aw_delay = awd; v.w_toggle = tog; v.bresp = bresp;
    v.corrupt_beat = cb; v.corrupt_all = ca; v.rlast_beat = rl; v.rresp_beat = rr;
    v.exp_status = es; v.exp_mism = em;
    return v;
  endfunction

  // Reference outcome of a command, straight from the command rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   words  = (int'(v.addr) % 4096) / 4;
    bit   bad    = (int'(v.addr) % 4 != 0) || (words + int'(v.len) > 1023);
    bit   early  = (v.rlast_beat >= 0) && (v.rlast_beat < int'(v.len));
    int   got    = early ? v.rlast_beat + 1 : int'(v.len) + 1;
    int   nmis;
    r.exp_mism = 8'd0;
    if (bad) begin
      r.exp_status = 2'b11;
    end else if (v.wr) begin
      r.exp_status = (v.bresp == 2'b00) ? 2'b00 : 2'b10;
    end else begin
      if (early || v.rlast_beat == -2)                       r.exp_status = 2'b01;
      else if (v.rresp_beat >= 0 && v.rresp_beat < got)      r.exp_status = 2'b10;
      else                                                   r.exp_status = 2'b00;
      nmis = v.corrupt_all ? got : ((v.corrupt_beat >= 0 && v.corrupt_beat < got) ? 1 : 0);
      r.exp_mism = (nmis > 255) ? 8'd255 : 8'(nmis);
    end
    return r;
  endfunction

  task automatic idle_slave();
    AWREADY = 0; ARREADY = 0; WREADY = 0;
    BVALID = 0; BRESP = 0;
    RVALID = 0; RLAST = 0; RRESP = 0; RDATA = '0;
  endtask

  // Issue one command (entered and left on a falling edge) and act as slave.
  task automatic run_cmd(input vec_t v);
    int  cyc = 1, aw_cnt = 0, wbeats = 0, rsent = 0, lat = -1, last_hs = -1, done_cyc = -1;
    int  rlast_at, rtotal;
    bit  illegal = (v.exp_status == 2'b11);
    bit  b_done = 0, tog = 0, saw_ax = 0, aw_hs = 0, ar_hs = 0, finished = 0;
    logic [1:0] st = 2'b00;
    logic [7:0] mm = 8'd0;

    rlast_at = (v.rlast_beat == -1) ? int'(v.len) : v.rlast_beat;
    rtotal   = (v.rlast_beat >= 0 && v.rlast_beat < int'(v.len)) ? v.rlast_beat + 1 : int'(v.len) + 1;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_seed = v.seed;
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 0;
    check("cmd_ready_busy", cmd_ready, 0);
    check("mism_clear_on_accept", mismatch_cnt, 0);

    while (!finished && cyc < 1000) begin
      if (AWVALID || ARVALID) begin
        if (!saw_ax) lat = cyc;
        saw_ax = 1;
      end
      if (aw_hs) begin
        check("awvalid_drop", AWVALID, 0);
        check("wvalid_after_aw", WVALID, 1);
      end
      if (ar_hs) begin
        check("arvalid_drop", ARVALID, 0);
        check("rready_after_ar", RREADY, 1);
      end
      aw_hs = 0; ar_hs = 0;
      idle_slave();

      if (AWVALID) begin
        check("awaddr", AWADDR, v.addr);
        check("awlen", AWLEN, v.len);
        check("awsize", AWSIZE, 3'b010);
        if (aw_cnt >= v.aw_delay) begin AWREADY = 1; aw_hs = 1; end
        aw_cnt++;
      end
      if (ARVALID) begin
        check("araddr", ARADDR, v.addr);
        check("arlen", ARLEN, v.len);
        check("arsize", ARSIZE, 3'b010);
        if (aw_cnt >= v.aw_delay) begin ARREADY = 1; ar_hs = 1; end
        aw_cnt++;
      end
      // response only after the final W beat has been accepted
      if (v.wr && wbeats == int'(v.len) + 1 && !b_done) begin
        BVALID = 1; BRESP = v.bresp;
        if (BREADY) begin b_done = 1; last_hs = cyc; end
      end
      if (WVALID) begin
        check("wdata", WDATA, v.seed + 32'(wbeats));
        check("wlast", WLAST, wbeats == int'(v.len));
        WREADY = v.w_toggle ? tog : 1'b1;
        if (WREADY) wbeats++;
      end
      tog = ~tog;
      if (RREADY && rsent < rtotal) begin
        RVALID = 1;
        RDATA  = v.seed + 32'(rsent);
        if (v.corrupt_all || rsent == v.corrupt_beat) RDATA = RDATA ^ 32'h0000_0100;
        RLAST  = (rsent == rlast_at);
        RRESP  = (rsent == v.rresp_beat) ? 2'b10 : 2'b00;
        rsent++;
        last_hs = cyc;
      end
      if (done) begin
        st = status; mm = mismatch_cnt; done_cyc = cyc; finished = 1;
      end
      @(posedge ACLK);
      @(negedge ACLK);
      cyc++;
    end
    idle_slave();

    check("done_within_budget", finished, 1);
    if (finished) begin
      check("status", st, v.exp_status);
      check("mismatch_cnt", mm, v.exp_mism);
      check("done_one_cycle", done, 0);
      check("cmd_ready_after_done", cmd_ready, 1);
      check("mismatch_hold", mismatch_cnt, v.exp_mism);
      check("axvalid_seen", saw_ax, !illegal);
      check("w_handshakes", wbeats, (v.wr && !illegal) ? int'(v.len) + 1 : 0);
      if (illegal) begin
        check("illegal_done_cycle", done_cyc, 2);
      end else begin
        check("accept_to_axvalid", lat, 2);
        check("last_hs_to_done", done_cyc - last_hs, 1);
      end
    end
  endtask

  vec_t tbl[18];
  vec_t rv;

  initial begin
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    idle_slave();

    tbl[0]  = mk(1, 16'h0100, 8'd3,   32'hA000_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[1]  = mk(0, 16'h0100, 8'd3,   32'hA000_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[2]  = mk(0, 16'h0100, 8'd3,   32'hA000_0000, 0, 0, 2'b00,  2, 0, -1, -1, 2'b00, 8'd1);
    tbl[3]  = mk(1, 16'h0100, 8'd3,   32'hA000_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[4]  = mk(1, 16'h0FFC, 8'd1,   32'h0000_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b11, 8'd0);
    tbl[5]  = mk(0, 16'h0102, 8'd0,   32'h0000_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b11, 8'd0);
    tbl[6]  = mk(1, 16'h0200, 8'd3,   32'h5555_0000, 5, 1, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[7]  = mk(1, 16'h0300, 8'd2,   32'h0000_1000, 0, 0, 2'b10, -1, 0, -1, -1, 2'b10, 8'd0);
    tbl[8]  = mk(0, 16'h0400, 8'd3,   32'h0000_2000, 0, 0, 2'b00, -1, 0,  1, -1, 2'b01, 8'd0);
    tbl[9]  = mk(0, 16'h0400, 8'd3,   32'h0000_2000, 0, 0, 2'b00, -1, 0, -1,  0, 2'b10, 8'd0);
    tbl[10] = mk(0, 16'h0400, 8'd3,   32'h0000_2000, 0, 0, 2'b00, -1, 0, -2, -1, 2'b01, 8'd0);
    tbl[11] = mk(0, 16'h0FFC, 8'd0,   32'hFFFF_FFFF, 0, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[12] = mk(1, 16'h0F00, 8'd63,  32'hFFFF_FFF0, 0, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[13] = mk(1, 16'h0F00, 8'd64,  32'h0000_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b11, 8'd0);
    tbl[14] = mk(0, 16'h0000, 8'd255, 32'h1234_5678, 0, 0, 2'b00, -1, 1, -1, -1, 2'b00, 8'd255);
    tbl[15] = mk(0, 16'h0500, 8'd3,   32'h0000_3000, 0, 0, 2'b00, -1, 0,  1,  0, 2'b01, 8'd0);
    tbl[16] = mk(1, 16'h0600, 8'd0,   32'hCAFE_0000, 0, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);
    tbl[17] = mk(0, 16'h0700, 8'd3,   32'h0000_4000, 5, 0, 2'b00, -1, 0, -1, -1, 2'b00, 8'd0);

    // ---- reset values ----
    cmd_valid = 1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {AWVALID, WVALID, ARVALID}, 3'b000);
    check("rst_readies", {BREADY, RREADY}, 2'b00);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_mismatch", mismatch_cnt, 0);
    cmd_valid = 0;
    ARESET = 0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // ---- directed table ----
    for (int i = 0; i < 18; i++) begin
      cur_id = i;
      run_cmd(tbl[i]);
    end

    // ---- reset in the middle of a write burst ----
    cur_id = 100;
    begin
      int  beats = 0;
      bit  hit = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0800; cmd_len = 8'd3; cmd_seed = 32'h1234_0000;
      @(posedge ACLK); @(negedge ACLK);
      cmd_valid = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
        idle_slave();
        if (AWVALID) AWREADY = 1;
        if (WVALID) begin
          if (beats == 2) begin
            hit = 1;
            check("wdata_beat2", WDATA, 32'h1234_0002);
            ARESET = 1;
          end else begin
            WREADY = 1;
            beats++;
          end
        end
        if (!hit) begin @(posedge ACLK); @(negedge ACLK); end
      end
      check("reached_beat2", hit, 1);
      @(posedge ACLK); @(negedge ACLK);
      idle_slave();
      check("mid_rst_valids", {AWVALID, WVALID, ARVALID}, 3'b000);
      check("mid_rst_readies", {BREADY, RREADY, cmd_ready}, 3'b000);
      check("mid_rst_done", done, 0);
      ARESET = 0;
      @(posedge ACLK); @(negedge ACLK);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      for (int c = 0; c < 4; c++) begin
        check("abandoned_no_done", {done, AWVALID, WVALID}, 3'b000);
        @(posedge ACLK); @(negedge ACLK);
      end
    end
    cur_id = 101;
    run_cmd(tbl[0]);

    // ---- randomized commands against the model ----
    for (int i = 0; i < 40; i++) begin
      cur_id = 200 + i;
      rv.wr   = $urandom_range(0, 1);
      rv.addr = 16'($urandom) & 16'hFFFC;
      if ($urandom_range(0, 7) == 0) rv.addr = rv.addr + 16'($urandom_range(1, 3));
      rv.len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      rv.seed = $urandom;
      rv.aw_delay = $urandom_range(0, 3);
      rv.w_toggle = $urandom_range(0, 1);
      rv.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.corrupt_beat = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, int'(rv.len));
      rv.corrupt_all  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       rv.rlast_beat = (rv.len > 0) ? $urandom_range(0, int'(rv.len) - 1) : -1;
        1:       rv.rlast_beat = -2;
        default: rv.rlast_beat = -1;
      endcase
      rv.rresp_beat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rv.len)) : -1;
      rv = model(rv);
      run_cmd(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
